enc_for_controller: RTL and testbench
=====================================

# enc_for_controller

Sequencing and buffering controller for the encoder output formatter. It takes variable-length symbol beats from the encoder core and owns the 2·ENC_SYM_NUM-symbol carry buffer (`buf_data`). Each cycle it drives `for_phase`, `for_request` and `for_offset` so that the combinational formatter emits dense, in-order beats of ENC_SYM_NUM symbols, with a short final beat at each frame end. It also runs the valid/ready handshakes on both sides of the formatter.

## Interface
Parameters come from encoder.vh (N = ENC_SYM_NUM, E = EGF_ORDER).
- ENC_SYM_NUM, 8, symbols per beat (N ≥ 2)
- EGF_ORDER, 8, bits per symbol

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset; synchronous, active-high (asserted = 1, despite the suffix)
- in_valid  in  1  encoder beat valid
- in_ready  out  1  controller accepts beat
- in_count  in  $clog2(N+1)  number of valid symbols, packed in the top lanes N-in_count..N-1 of enc_data; the oldest symbol is in lane N-1
- in_last  in  1  beat ends the frame
- enc_data  in  N×E  encoder symbols; the same net also feeds the formatter
- buf_data  out  2N×E  carry buffer; valid symbols are in lanes 0..cnt-1, oldest at the highest lane
- for_phase  out  FOR_PHASE  FOR_IDLE / FOR_DATA / FOR_FLUSH
- for_request  out  $clog2(N+1)  symbols in the current output beat
- for_offset  out  $clog2(2N-1)  formatter window offset
- out_valid  out  1  formatter output beat valid
- out_ready  in  1  downstream accepts beat
- out_last  out  1  beat is the last of the frame

## Operation
- Internal state:
  - cnt, 0..2N-1: buffered symbol count.
  - buf: 2N symbol registers.
  - FSM with states IDLE, DATA, FLUSH, driven onto for_phase as FOR_IDLE / FOR_DATA / FOR_FLUSH.
- Data view: T = {buf, enc_data}, lane index 0..3N-1. Valid symbols occupy T[N-k .. N+cnt-1], where k = in_count if in_fire, else 0. Older symbols sit at higher indices.
- Handshake signals:
  - in_ready = (state ≠ FLUSH) && (cnt < N).
  - in_fire = in_valid && in_ready.
  - avail = cnt + k.
- Request selection:
  - If avail ≥ N: for_request = N, out_valid = 1.
  - Else, if in_fire && in_last (state DATA/IDLE), or state FLUSH: for_request = avail, out_valid = 1, out_last = 1.
  - Otherwise out_valid = 0 and for_request = 0.
- In FLUSH with cnt ≥ N, a full beat is emitted with out_last = 0.
- for_offset = N + cnt − for_request. The result is always ≤ 2N−1 and is forced to 0 when out_valid = 0.
- Removal on out_fire: out_fire = out_valid && out_ready removes r = for_request symbols (the oldest). Otherwise r = 0.
- Buffer update:
  - new cnt = avail − r.
  - new buf[j] = T[N−k+j] for j < new cnt, else 0.
  - Symbol order is preserved and no symbol is duplicated or dropped.
- Input is absorbed on in_fire regardless of out_ready. Output stalls never lose data.
- FSM transitions:
  - IDLE→DATA on in_fire && !in_last.
  - DATA/IDLE: an in_fire with in_last whose last beat also fires this cycle (avail ≤ N and out_ready) → IDLE.
  - In any other in_last case → FLUSH.
  - FLUSH→IDLE on out_fire with out_last.
  - IDLE is re-entered with cnt = 0.
- Zero-length frame (in_last, k = 0, cnt = 0): one beat with for_request = 0, out_last = 1, all-zero data.
- for_phase = FOR_IDLE in IDLE, FOR_DATA in DATA, FOR_FLUSH in FLUSH.

## Timing
- Pass-through is combinational. An output beat built from an input beat is valid in the same cycle. Buffer and state update on the clk edge.
- Reset, sampled at the edge:
  - cnt = 0, buf = 0, state IDLE.
  - Outputs: for_phase = FOR_IDLE, for_request = 0, for_offset = 0, out_valid = 0, out_last = 0, buf_data = 0.
  - in_ready = 0 while rst_n = 1 and 1 in the first cycle after release.
- Reset mid-frame discards the buffered symbols and the frame. The next beat after release starts a new frame.
- Back-pressure: with out_ready = 0, up to 2N−1 symbols are held. in_ready is low whenever cnt ≥ N, and drain beats are buffer-only (for_offset = cnt ≥ N).
- Throughput is one full output beat per cycle when in_count = N and out_ready = 1. The FLUSH tail adds ≤ 2 cycles after in_last.
- in_ready and out_valid are combinational from registered state and current inputs. There is no combinational path from out_ready to in_ready.

## Test plan
(N = 8, E = 8 throughout.)
- Full beats: 3 beats with in_count = 8, out_ready = 1, last on the 3rd → 3 same-cycle outputs with request 8, offset 0; out_last only on the 3rd; cnt stays 0; IDLE.
- Repack: in_count 5, 5, 6(last) with out_ready = 1 →
  - cycle 0: no output, cnt = 5.
  - cycle 1: request 8, offset 5, cnt = 2.
  - cycle 2: request 8, offset 2, out_last, IDLE.
  - Symbol order matches input order.
- Back-pressure: out_ready = 0, beat with in_count = 8 → cnt = 8, in_ready = 0. Then out_ready = 1 → buffer-only beat with request 8, offset 8, cnt = 0, in_ready = 1.
- Tail flush: cnt = 7 (in DATA), then a beat with in_count = 8 and in_last, out_ready = 1 →
  - same cycle: request 8, offset 7; FLUSH entered.
  - next cycle: request 7, offset 8, out_last, FOR_FLUSH.
  - then IDLE.
- Zero-length frame: in_last with in_count = 0 from IDLE → request 0, out_last = 1, zero data; remains IDLE.
- Reset mid-frame: cnt = 5 in DATA, rst_n = 1 for one edge → cnt = 0, buf_data = 0, FOR_IDLE, in_ready = 1 after release; no stale symbols in the next frame.

Source files
------------

// File: rtl/enc_for_controller_if.sv
// Bus bundle shared by the encoder core, the output controller, the
// combinational formatter and the downstream sink.
interface enc_for_controller_if #(
  parameter int N = 8,
  parameter int E = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [$clog2(N+1)-1:0]   in_count;
  logic                     in_last;
  logic [N*E-1:0]           enc_data;
  logic [2*N*E-1:0]         buf_data;
  logic [1:0]               for_phase;
  logic [$clog2(N+1)-1:0]   for_request;
  logic [$clog2(2*N-1)-1:0] for_offset;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  // Environment side: encoder core upstream plus downstream sink
  modport master (
    output in_valid, in_count, in_last, enc_data, out_ready,
    input  in_ready, buf_data, for_phase, for_request, for_offset, out_valid, out_last
  );

  // Controller side
  modport slave (
    input  in_valid, in_count, in_last, enc_data, out_ready,
    output in_ready, buf_data, for_phase, for_request, for_offset, out_valid, out_last
  );
endinterface

// File: rtl/enc_for_controller.sv
// Encoder output controller: owns the 2N-symbol carry buffer and steers the
// combinational formatter so it emits dense, in-order N-symbol beats with a
// short final beat at each frame end. Both handshakes are resolved here.
module enc_for_controller #(
  parameter int ENC_SYM_NUM = 8,
  parameter int EGF_ORDER   = 8
) (
  input logic                 clk,
  input logic                 rst_n,   // synchronous, active-high
  enc_for_controller_if.slave bus
);
  localparam int N  = ENC_SYM_NUM;
  localparam int E  = EGF_ORDER;
  localparam int CW = $clog2(2*N) + 1;     // holds N + (2N-1)
  localparam int RW = $clog2(N+1);
  localparam int OW = $clog2(2*N-1);
  localparam int SW = $clog2(3*N*E) + 1;
  localparam int BW = 2*N*E;
  localparam logic [CW-1:0] N_C = CW'(N);

  localparam logic [1:0] FOR_IDLE  = 2'd0;
  localparam logic [1:0] FOR_DATA  = 2'd1;
  localparam logic [1:0] FOR_FLUSH = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t          r_state;
  logic [1:0]      r_phase;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_buf;

  logic            w_in_ready;
  logic            w_in_fire;
  logic [CW-1:0]   w_k;
  logic [CW-1:0]   w_kf;
  logic [CW-1:0]   w_avail;
  logic [CW-1:0]   w_req;
  logic            w_valid;
  logic            w_last;
  logic            w_out_fire;
  logic [CW-1:0]   w_rem;
  logic [CW-1:0]   w_new_cnt;
  logic [CW-1:0]   w_drop;
  logic [SW-1:0]   w_shamt;
  logic [3*N*E-1:0] w_t;
  logic [BW-1:0]   w_shift;
  logic [BW-1:0]   w_new_buf;

  // Clamp an out-of-range symbol count so the buffer can never overrun
  always_comb begin
    if (CW'(bus.in_count) > N_C) begin
      w_k = N_C;
    end else begin
      w_k = CW'(bus.in_count);
    end
  end

  // No input while draining a frame tail or once a full beat is already held
  assign w_in_ready = !rst_n && (r_state != S_FLUSH) && (r_cnt < N_C);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_kf       = w_in_fire ? w_k : {CW{1'b0}};
  assign w_avail    = r_cnt + w_kf;

  // Pick the size of this cycle's output beat and whether it closes the frame
  always_comb begin
    w_req   = {CW{1'b0}};
    w_valid = 1'b0;
    w_last  = 1'b0;
    if (rst_n) begin
      w_valid = 1'b0;
    end else if (w_avail >= N_C) begin
      w_req   = N_C;
      w_valid = 1'b1;
      // A full beat closes the frame only when it holds exactly the tail
      w_last  = (r_state != S_FLUSH) && w_in_fire && bus.in_last && (w_avail == N_C);
    end else if (((r_state != S_FLUSH) && w_in_fire && bus.in_last) || (r_state == S_FLUSH)) begin
      w_req   = w_avail;
      w_valid = 1'b1;
      w_last  = 1'b1;
    end else begin
      w_valid = 1'b0;
    end
  end

  assign w_out_fire = w_valid && bus.out_ready;
  assign w_rem      = w_out_fire ? w_req : {CW{1'b0}};
  assign w_new_cnt  = w_avail - w_rem;

  // Window {buf, enc_data} shifted so the oldest surviving symbol lands at lane new_cnt-1
  assign w_t     = {r_buf, bus.enc_data};
  assign w_drop  = N_C - w_kf;
  assign w_shamt = SW'(w_drop) * SW'(E);
  assign w_shift = BW'(w_t >> w_shamt);

  // Keep only the surviving symbols; unused lanes are cleared
  always_comb begin
    w_new_buf = {BW{1'b0}};
    for (int j = 0; j < 2*N; j++) begin
      if (CW'(j) < w_new_cnt) begin
        w_new_buf[j*E +: E] = w_shift[j*E +: E];
      end else begin
        w_new_buf[j*E +: E] = {E{1'b0}};
      end
    end
  end

  // Frame FSM; for_phase is registered alongside the state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_phase <= FOR_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DATA: begin
          if (w_in_fire && bus.in_last) begin
            if ((w_avail <= N_C) && bus.out_ready) begin
              r_state <= S_IDLE;
              r_phase <= FOR_IDLE;
            end else begin
              r_state <= S_FLUSH;
              r_phase <= FOR_FLUSH;
            end
          end else if (w_in_fire) begin
            r_state <= S_DATA;
            r_phase <= FOR_DATA;
          end else begin
            r_state <= r_state;
            r_phase <= r_phase;
          end
        end
        S_FLUSH: begin
          if (w_out_fire && w_last) begin
            r_state <= S_IDLE;
            r_phase <= FOR_IDLE;
          end else begin
            r_state <= S_FLUSH;
            r_phase <= FOR_FLUSH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_phase <= FOR_IDLE;
        end
      endcase
    end
  end

  // Carry buffer and symbol count
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_buf <= {BW{1'b0}};
    end else begin
      r_cnt <= w_new_cnt;
      r_buf <= w_new_buf;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_valid;
  assign bus.out_last    = w_last;
  assign bus.for_request = RW'(w_req);
  assign bus.for_offset  = w_valid ? OW'(N_C + r_cnt - w_req) : {OW{1'b0}};
  assign bus.for_phase   = r_phase;
  assign bus.buf_data    = r_buf;
endmodule

// File: tb/tb_enc_for_controller.sv
// Bench for enc_for_controller: directed vector table, hand-written reset
// sequence and random traffic, all compared against a queue-based model.
module tb_enc_for_controller;
  localparam int N = 8;
  localparam int E = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  enc_for_controller_if #(.N(N), .E(E)) bus();

  enc_for_controller #(.ENC_SYM_NUM(N), .EGF_ORDER(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic v; int c; logic l; logic o;
    int req; int off; logic val; logic lst; logic rdy; int ph; int cnt_after;
  } vec_t;

  vec_t tbl[17];
  int checks = 0;
  int errors = 0;
  logic [E-1:0] q[$];
  int m_ph = 0;
  int seq = 1;
  logic [63:0] s_req, s_off, s_ph, s_val, s_last, s_rdy;
  int s_bufcnt;
  logic [N*E-1:0] d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [2*N*E-1:0] act, input logic [2*N*E-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fresh nonzero symbols in the top c lanes, junk below them
  task automatic make_data(input int c, output logic [N*E-1:0] dd);
    for (int i = 0; i < N; i++) dd[i*E +: E] = E'($urandom());
    for (int i = 0; i < c; i++) begin
      dd[(N-1-i)*E +: E] = E'(seq);
      seq = seq % 255 + 1;
    end
  endtask

  // One clock: drive, check at negedge against the model, advance model at posedge
  task automatic step(input logic rst, input logic v, input int c, input logic l,
                      input logic [N*E-1:0] dd, input logic o);
    logic [E-1:0] all[$];
    int cnt, k, avail, req, off, lane, n;
    logic rdy, fire, val, lst;
    logic [2*N*E-1:0] ebuf;
    logic [3*N*E-1:0] tv;
    rst_n = rst;
    bus.in_valid = v; bus.in_count = 4'(c); bus.in_last = l;
    bus.enc_data = dd; bus.out_ready = o;
    @(negedge clk);
    s_req = 64'(bus.for_request); s_off = 64'(bus.for_offset); s_ph = 64'(bus.for_phase);
    s_val = 64'(bus.out_valid); s_last = 64'(bus.out_last); s_rdy = 64'(bus.in_ready);
    if (rst) begin
      chk("rst_in_ready", s_rdy, 0);
      chk("rst_out_valid", s_val, 0);
      chk("rst_request", s_req, 0);
      chk("rst_offset", s_off, 0);
      chk("rst_last", s_last, 0);
      @(posedge clk); #1;
      q.delete();
      m_ph = 0;
    end else begin
      cnt = q.size();
      rdy = (m_ph != 2) && (cnt < N);
      fire = v && rdy;
      k = fire ? c : 0;
      all = q;
      for (int i = 0; i < k; i++) all.push_back(dd[(N-1-i)*E +: E]);
      avail = all.size();
      val = 1'b0; lst = 1'b0; req = 0;
      if (avail >= N) begin
        req = N; val = 1'b1;
        lst = (m_ph != 2) && fire && l && (avail == N);
      end else if (((m_ph != 2) && fire && l) || (m_ph == 2)) begin
        req = avail; val = 1'b1; lst = 1'b1;
      end
      off = val ? (N + cnt - req) : 0;
      ebuf = '0;
      for (int i = 0; i < cnt; i++) ebuf[(cnt-1-i)*E +: E] = q[i];
      chk("in_ready", s_rdy, 64'(rdy));
      chk("out_valid", s_val, 64'(val));
      chk("out_last", s_last, 64'(lst));
      chk("for_request", s_req, req);
      chk("for_offset", s_off, off);
      chk("for_phase", s_ph, m_ph);
      chk_w("buf_data", bus.buf_data, ebuf);
      if (val && o) begin
        tv = {bus.buf_data, bus.enc_data};
        for (int i = 0; i < req; i++) begin
          lane = int'(s_off) + int'(s_req) - 1 - i;
          if (lane >= 0 && lane < 3*N) begin
            chk("beat_symbol", 64'(tv[lane*E +: E]), 64'(all[i]));
          end else begin
            checks++; errors++;
            $display("FAIL beat_lane: got lane %0d expected 0..%0d at %0t", lane, 3*N-1, $time);
          end
        end
        for (int i = 0; i < req; i++) void'(all.pop_front());
      end
      if (m_ph != 2) begin
        if (fire && l) m_ph = ((avail <= N) && o) ? 0 : 2;
        else if (fire) m_ph = 1;
      end else if (val && o && lst) begin
        m_ph = 0;
      end
      q = all;
      @(posedge clk); #1;
    end
    n = 0;
    for (int i = 0; i < 2*N; i++) if (bus.buf_data[i*E +: E] != '0) n++;
    s_bufcnt = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              v   c  l   o  req off val lst rdy ph cnt
    tbl[0]  = '{1'b1, 8, 1'b0, 1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[1]  = '{1'b1, 8, 1'b0, 1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 1, 0};
    tbl[2]  = '{1'b1, 8, 1'b1, 1'b1, 8, 0, 1'b1, 1'b1, 1'b1, 1, 0};
    tbl[3]  = '{1'b1, 5, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 5};
    tbl[4]  = '{1'b1, 5, 1'b0, 1'b1, 8, 5, 1'b1, 1'b0, 1'b1, 1, 2};
    tbl[5]  = '{1'b1, 6, 1'b1, 1'b1, 8, 2, 1'b1, 1'b1, 1'b1, 1, 0};
    tbl[6]  = '{1'b1, 8, 1'b0, 1'b0, 8, 0, 1'b1, 1'b0, 1'b1, 0, 8};
    tbl[7]  = '{1'b0, 0, 1'b0, 1'b1, 8, 8, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[8]  = '{1'b1, 7, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1, 7};
    tbl[9]  = '{1'b1, 8, 1'b1, 1'b1, 8, 7, 1'b1, 1'b0, 1'b1, 1, 7};
    tbl[10] = '{1'b0, 0, 1'b0, 1'b1, 7, 8, 1'b1, 1'b1, 1'b0, 2, 0};
    tbl[11] = '{1'b1, 0, 1'b1, 1'b1, 0, 8, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[12] = '{1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[13] = '{1'b1, 3, 1'b1, 1'b0, 3, 5, 1'b1, 1'b1, 1'b1, 0, 3};
    tbl[14] = '{1'b1, 8, 1'b0, 1'b0, 3, 8, 1'b1, 1'b1, 1'b0, 2, 3};
    tbl[15] = '{1'b0, 0, 1'b0, 1'b1, 3, 8, 1'b1, 1'b1, 1'b0, 2, 0};
    tbl[16] = '{1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0};

    // Reset with traffic present
    make_data(8, d);
    step(1'b1, 1'b1, 8, 1'b0, d, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, d, 1'b1);
    chk_w("reset_buf_data", bus.buf_data, '0);
    chk("reset_phase", 64'(bus.for_phase), 0);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      make_data(tbl[i].c, d);
      step(1'b0, tbl[i].v, tbl[i].c, tbl[i].l, d, tbl[i].o);
      chk("tbl_request", s_req, tbl[i].req);
      chk("tbl_offset", s_off, tbl[i].off);
      chk("tbl_valid", s_val, 64'(tbl[i].val));
      chk("tbl_last", s_last, 64'(tbl[i].lst));
      chk("tbl_ready", s_rdy, 64'(tbl[i].rdy));
      chk("tbl_phase", s_ph, tbl[i].ph);
      chk("tbl_cnt_after", s_bufcnt, tbl[i].cnt_after);
    end

    // Reset mid-frame discards buffered symbols
    make_data(5, d);
    step(1'b0, 1'b1, 5, 1'b0, d, 1'b1);
    chk("mid_cnt_before", s_bufcnt, 5);
    make_data(8, d);
    step(1'b1, 1'b1, 8, 1'b0, d, 1'b1);
    chk_w("mid_buf_cleared", bus.buf_data, '0);
    step(1'b0, 1'b0, 0, 1'b0, d, 1'b1);
    chk("mid_ready_after", s_rdy, 1);
    chk("mid_phase_after", s_ph, 0);
    make_data(8, d);
    step(1'b0, 1'b1, 8, 1'b1, d, 1'b1);
    chk("mid_new_request", s_req, 8);
    chk("mid_new_offset", s_off, 0);
    chk("mid_new_last", s_last, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic rr, vv, ll, oo;
      int cc;
      rr = ($urandom_range(0, 299) == 0);
      vv = ($urandom_range(0, 3) != 0);
      cc = $urandom_range(0, N);
      ll = ($urandom_range(0, 7) == 0);
      oo = ($urandom_range(0, 3) != 0);
      make_data(cc, d);
      step(rr, vv, cc, ll, d, oo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
